// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// ALU operation codes, opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_t;

  // Which family of ALU operation the current state asks for
  typedef enum logic [1:0] {
    CLS_ADD, CLS_EXECR, CLS_EXECI, CLS_BRANCH
  } alu_class_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b0011;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Branch decision from the compare result; funct3 010/011 never branch
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000, 3'b101, 3'b111: branch_taken = zero;
      3'b001, 3'b100, 3'b110: branch_taken = ~zero;
      default:                branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps the requested operation class plus funct3/funct7b5 onto the ALU code.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  alu_control
);

  // Combinational operation select; plain address/link arithmetic is ADD
  always_comb begin
    alu_control = ALU_ADD;
    case (cls)
      CLS_EXECR, CLS_EXECI: begin
        case (funct3)
          3'b000:  alu_control = (cls == CLS_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3)
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        alu_control = ALU_SUB;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback and issues every datapath enable and mux select.
module alu_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit RESET_TRAP = 1'b0
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic       jalr_ph, jalr_ph_nxt;
  alu_class_t alu_cls;

  alu_op_decode u_alu_op_decode (
    .cls         (alu_cls),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // State register plus the JALR phase flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      jalr_ph <= 1'b0;
    end else begin
      state   <= state_nxt;
      jalr_ph <= jalr_ph_nxt;
    end
  end

  // Next-state and output decode; reset overrides every enable
  always_comb begin
    state_nxt   = state;
    jalr_ph_nxt = jalr_ph;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_I;
    alu_cls     = CLS_ADD;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_BRANCH:         state_nxt = BRANCH;
          OP_JAL:            state_nxt = JAL;
          OP_JALR:           state_nxt = JALR;
          OP_LUI:            state_nxt = LUI;
          OP_AUIPC:          state_nxt = AUIPC;
          default:           state_nxt = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LOAD) begin
          imm_src   = IMM_I;
          state_nxt = MEMREAD;
        end else begin
          imm_src   = IMM_S;
          state_nxt = MEMWRITE;
        end
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_nxt = MEMWB;
      end
      MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_nxt = FETCH;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_cls   = CLS_EXECR;
        state_nxt = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_cls   = CLS_EXECI;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_nxt  = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        imm_src    = IMM_B;
        alu_cls    = CLS_BRANCH;
        pc_write   = branch_taken(funct3, zero);
        state_nxt  = FETCH;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        imm_src    = IMM_J;
        pc_write   = 1'b1;
        state_nxt  = ALUWB;
      end
      JALR: begin
        if (!jalr_ph) begin
          // First phase parks rs1+imm in the ALU output register
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          imm_src     = IMM_I;
          jalr_ph_nxt = 1'b1;
        end else begin
          // Second phase jumps to the parked target and forms the link
          alu_src_a   = SRCA_OLDPC;
          alu_src_b   = SRCB_FOUR;
          result_src  = RES_ALUOUT;
          pc_write    = 1'b1;
          jalr_ph_nxt = 1'b0;
          state_nxt   = ALUWB;
        end
      end
      LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = ALUWB;
      end
      AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_nxt = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
        if (!RESET_TRAP) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule
